multi_diff_sampler: RTL and testbench

Parametrised N-channel successor to the single-channel comparator-output sampler in the ultrasound receive path. Each channel synchronises a 1-bit differential-comparator input and counts its high cycles over a window of runtime-selectable power-of-two length. Optionally, it averages 2^A consecutive windows, then publishes all channel results with a one-cycle valid strobe, a per-channel peak hold and a window sequence number. It sits between the array's comparator pins and the PWM/LFSR re-modulation and scan-control logic, all on `pwm_clk`.

---
 rtl/multi_diff_sampler.sv | 182 ++++++++++++++++++
 tb/tb_multi_diff_sampler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_diff_sampler.sv
// N-channel comparator sampler: synchronise each input, count high cycles per 2^W window,
// average 2^A windows, then publish results with a valid strobe, peak hold and sequence number.
module multi_diff_sampler #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned MAX_WIN_LOG2 = 10,
    parameter int unsigned COUNT_W      = MAX_WIN_LOG2 + 1
) (
    input  logic                          pwm_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [3:0]                    win_log2,
    input  logic [1:0]                    avg_log2,
    input  logic                          peak_clr,
    input  logic [CHANNELS-1:0]           diff_in,
    output logic [CHANNELS*COUNT_W-1:0]   count_out,
    output logic                          count_valid,
    output logic [CHANNELS*COUNT_W-1:0]   peak_out,
    output logic [7:0]                    window_seq
);

    localparam int unsigned AccW = COUNT_W + 3;

    typedef enum logic {StIdle, StRun} state_e;

    state_e state_q, state_d;
    logic   count_en;

    logic [CHANNELS-1:0]         sync1_q, sync2_q;
    logic [MAX_WIN_LOG2-1:0]     win_cnt_q, win_cnt_d, win_mask;
    logic [2:0]                  win_num_q, win_num_d, avg_mask;
    logic [3:0]                  w_clamp, w_q, w_d, w_eff;
    logic [1:0]                  a_q, a_d, a_eff;
    logic                        grp_start, win_last, grp_last;
    logic [COUNT_W-1:0]          chan_cnt_q [CHANNELS];
    logic [COUNT_W-1:0]          chan_cnt_d [CHANNELS];
    logic [COUNT_W-1:0]          sum_c      [CHANNELS];
    logic [COUNT_W-1:0]          res_c      [CHANNELS];
    logic [AccW-1:0]             acc_q      [CHANNELS];
    logic [AccW-1:0]             acc_d      [CHANNELS];
    logic [AccW-1:0]             acc_sum    [CHANNELS];
    logic [CHANNELS*COUNT_W-1:0] count_q, count_d, peak_q, peak_d;
    logic                        valid_q, valid_d;
    logic [7:0]                  seq_q, seq_d;

    // ---------------- FSM ----------------
    always_ff @(posedge pwm_clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable)  state_d = StRun;
            StRun:   if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The first cycle sampled with enable high is already sample 0, so IDLE counts too.
    always_comb begin
        count_en = 1'b0;
        unique case (state_q)
            StIdle:  count_en = enable;
            StRun:   count_en = enable;
            default: count_en = 1'b0;
        endcase
    end

    // ---------------- Window / group control ----------------
    always_comb begin
        w_clamp = win_log2;
        if (win_log2 == 4'd0)                      w_clamp = 4'd1;
        else if (win_log2 > 4'(MAX_WIN_LOG2))      w_clamp = 4'(MAX_WIN_LOG2);
    end

    // Config is taken live on the group's first cycle and from the latch afterwards.
    assign grp_start = (win_cnt_q == '0) && (win_num_q == '0);
    assign w_eff     = grp_start ? w_clamp : w_q;
    assign a_eff     = grp_start ? avg_log2 : a_q;
    assign win_mask  = ~({MAX_WIN_LOG2{1'b1}} << w_eff);
    assign avg_mask  = ~(3'b111 << a_eff);
    assign win_last  = (win_cnt_q == win_mask);
    assign grp_last  = win_last && (win_num_q == avg_mask);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sum_c[c]   = chan_cnt_q[c] + COUNT_W'(sync2_q[c]);
            acc_sum[c] = acc_q[c] + AccW'(sum_c[c]);
            res_c[c]   = COUNT_W'(acc_sum[c] >> a_eff);
        end
    end

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_num_d = win_num_q;
        w_d       = w_q;
        a_d       = a_q;
        count_d   = count_q;
        peak_d    = peak_clr ? '0 : peak_q;
        valid_d   = 1'b0;
        seq_d     = seq_q;
        for (int c = 0; c < CHANNELS; c++) begin
            chan_cnt_d[c] = chan_cnt_q[c];
            acc_d[c]      = acc_q[c];
        end

        if (!count_en) begin
            win_cnt_d = '0;
            win_num_d = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                chan_cnt_d[c] = '0;
                acc_d[c]      = '0;
            end
        end else begin
            w_d       = w_eff;
            a_d       = a_eff;
            win_cnt_d = win_last ? '0 : win_cnt_q + 1'b1;
            if (win_last) win_num_d = grp_last ? 3'd0 : win_num_q + 3'd1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (win_last) begin
                    chan_cnt_d[c] = '0;
                    acc_d[c]      = grp_last ? '0 : acc_sum[c];
                end else begin
                    chan_cnt_d[c] = sum_c[c];
                end
                if (grp_last) begin
                    count_d[c*COUNT_W +: COUNT_W] = res_c[c];
                    // A coincident clear restarts the peak from the fresh result.
                    if (peak_clr || (res_c[c] > peak_q[c*COUNT_W +: COUNT_W])) begin
                        peak_d[c*COUNT_W +: COUNT_W] = res_c[c];
                    end
                end
            end
            if (grp_last) begin
                valid_d = 1'b1;
                seq_d   = seq_q + 8'd1;
            end
        end
    end

    // ---------------- State ----------------
    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            win_cnt_q <= '0;
            win_num_q <= '0;
            w_q       <= 4'd1;
            a_q       <= '0;
            count_q   <= '0;
            peak_q    <= '0;
            valid_q   <= 1'b0;
            seq_q     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                chan_cnt_q[c] <= '0;
                acc_q[c]      <= '0;
            end
        end else begin
            sync1_q   <= diff_in;
            sync2_q   <= sync1_q;
            win_cnt_q <= win_cnt_d;
            win_num_q <= win_num_d;
            w_q       <= w_d;
            a_q       <= a_d;
            count_q   <= count_d;
            peak_q    <= peak_d;
            valid_q   <= valid_d;
            seq_q     <= seq_d;
            for (int c = 0; c < CHANNELS; c++) begin
                chan_cnt_q[c] <= chan_cnt_d[c];
                acc_q[c]      <= acc_d[c];
            end
        end
    end

    assign count_out   = count_q;
    assign count_valid = valid_q;
    assign peak_out    = peak_q;
    assign window_seq  = seq_q;

endmodule

// File: tb/tb_multi_diff_sampler.sv
// Directed bench for multi_diff_sampler: windowing, averaging, peak hold, enable and reset.
module tb_multi_diff_sampler;

    localparam int CW = 11;

    logic          pwm_clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [3:0]    win_log2 = 4'd3;
    logic [1:0]    avg_log2 = 2'd0;
    logic          peak_clr = 1'b0;
    logic [1:0]    diff_in = 2'b00;
    logic [2*CW-1:0] count_out;
    logic          count_valid;
    logic [2*CW-1:0] peak_out;
    logic [7:0]    window_seq;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_mode = 0;
    int cyc      = 0;
    int exp_seq  = 0;

    multi_diff_sampler dut (
        .pwm_clk     (pwm_clk),
        .rst         (rst),
        .enable      (enable),
        .win_log2    (win_log2),
        .avg_log2    (avg_log2),
        .peak_clr    (peak_clr),
        .diff_in     (diff_in),
        .count_out   (count_out),
        .count_valid (count_valid),
        .peak_out    (peak_out),
        .window_seq  (window_seq)
    );

    always #5 pwm_clk = ~pwm_clk;

    // Input pattern for sample index s; bit 0 is channel 0.
    function automatic logic [1:0] pat(input int mode, input int s);
        logic c0, c1;
        int   k, lim;
        c0 = 1'b0;
        c1 = 1'b0;
        case (mode)
            0: begin c0 = 1'b1; c1 = 1'b0; end
            1: begin c0 = s[0]; c1 = ~s[0]; end
            2: begin c0 = (((s >> 4) & 1) == 0); c1 = 1'b1; end
            3: begin c0 = (s != 63); c1 = (s == 0); end
            4: begin
                k   = (s / 16) % 4;
                lim = (k == 0) ? 5 : (k == 1) ? 9 : 3;
                c0  = ((s % 16) < lim);
                c1  = 1'b1;
            end
            default: begin c0 = 1'b0; c1 = 1'b1; end
        endcase
        return {c1, c0};
    endfunction

    function automatic logic [CW-1:0] ch(input logic [2*CW-1:0] v, input int c);
        return v[c*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge pwm_clk);
        #1;
    endtask

    task automatic step();
        tick();
        cyc++;
        diff_in = pat(cur_mode, cyc + 2);
    endtask

    // Two lead cycles prime the synchroniser so sample 0 sees pat(mode, 0).
    task automatic start_run(input int mode);
        cur_mode = mode;
        enable   = 1'b0;
        diff_in  = pat(mode, 0);
        tick();
        diff_in  = pat(mode, 1);
        tick();
        enable   = 1'b1;
        cyc      = 0;
        diff_in  = pat(mode, 2);
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (count_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic stop();
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (count_out !== '0) $display("FAIL rst_count: got %h want 0", count_out); else n_pass++;
        n_checks++; if (peak_out !== '0) $display("FAIL rst_peak: got %h want 0", peak_out); else n_pass++;
        n_checks++; if (count_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", count_valid); else n_pass++;
        n_checks++; if (window_seq !== 8'd0) $display("FAIL rst_seq: got %0d want 0", window_seq); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        win_log2 = 4'd3;
        avg_log2 = 2'd0;
        start_run(0);
        for (int k = 0; k < 3; k++) begin
            wait_valid(20, lat);
            exp_seq++;
            n_checks++; if (lat !== 8) $display("FAIL basic_lat%0d: got %0d want 8", k, lat); else n_pass++;
            n_checks++; if (ch(count_out, 0) !== 11'd8) $display("FAIL basic_ch0_%0d: got %0d want 8", k, ch(count_out, 0)); else n_pass++;
            n_checks++; if (ch(count_out, 1) !== 11'd0) $display("FAIL basic_ch1_%0d: got %0d want 0", k, ch(count_out, 1)); else n_pass++;
            n_checks++; if (window_seq !== 8'(exp_seq)) $display("FAIL basic_seq%0d: got %0d want %0d", k, window_seq, exp_seq); else n_pass++;
        end
        step();
        n_checks++; if (count_valid !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", count_valid); else n_pass++;
        stop();
    endtask

    task automatic test_toggle_and_full();
        int lat;
        win_log2 = 4'd7;
        start_run(1);
        wait_valid(200, lat);
        exp_seq++;
        n_checks++; if (lat !== 128) $display("FAIL toggle_lat: got %0d want 128", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd64) $display("FAIL toggle_ch0: got %0d want 64", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(count_out, 1) !== 11'd64) $display("FAIL toggle_ch1: got %0d want 64", ch(count_out, 1)); else n_pass++;
        stop();
        win_log2 = 4'd10;
        start_run(0);
        wait_valid(1100, lat);
        exp_seq++;
        n_checks++; if (lat !== 1024) $display("FAIL full_lat: got %0d want 1024", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd1024) $display("FAIL full_ch0: got %0d want 1024", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(count_out, 1) !== 11'd0) $display("FAIL full_ch1: got %0d want 0", ch(count_out, 1)); else n_pass++;
        n_checks++; if (ch(peak_out, 0) !== 11'd1024) $display("FAIL full_peak0: got %0d want 1024", ch(peak_out, 0)); else n_pass++;
        stop();
    endtask

    task automatic test_average();
        int lat;
        win_log2 = 4'd4;
        avg_log2 = 2'd2;
        start_run(2);
        wait_valid(100, lat);
        exp_seq++;
        n_checks++; if (lat !== 64) $display("FAIL avg_lat: got %0d want 64", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd8) $display("FAIL avg_ch0: got %0d want 8", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(count_out, 1) !== 11'd16) $display("FAIL avg_ch1: got %0d want 16", ch(count_out, 1)); else n_pass++;
        start_run(3);
        wait_valid(100, lat);
        exp_seq++;
        n_checks++; if (lat !== 64) $display("FAIL floor_lat: got %0d want 64", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd15) $display("FAIL floor_ch0: got %0d want 15", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(count_out, 1) !== 11'd0) $display("FAIL floor_ch1: got %0d want 0", ch(count_out, 1)); else n_pass++;
        stop();
        avg_log2 = 2'd0;
    endtask

    task automatic test_win_change();
        int lat;
        win_log2 = 4'd3;
        start_run(0);
        repeat (4) step();
        win_log2 = 4'd5;
        wait_valid(20, lat);
        exp_seq++;
        n_checks++; if (lat !== 4) $display("FAIL wchg_lat1: got %0d want 4", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd8) $display("FAIL wchg_ch0_1: got %0d want 8", ch(count_out, 0)); else n_pass++;
        wait_valid(50, lat);
        exp_seq++;
        n_checks++; if (lat !== 32) $display("FAIL wchg_lat2: got %0d want 32", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd32) $display("FAIL wchg_ch0_2: got %0d want 32", ch(count_out, 0)); else n_pass++;
        stop();
    endtask

    task automatic test_peak();
        int lat;
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        n_checks++; if (peak_out !== '0) $display("FAIL peak_clr_idle: got %h want 0", peak_out); else n_pass++;
        win_log2 = 4'd4;
        start_run(4);
        wait_valid(20, lat);
        exp_seq++;
        n_checks++; if (ch(count_out, 0) !== 11'd5) $display("FAIL peak_cnt1: got %0d want 5", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(peak_out, 0) !== 11'd5) $display("FAIL peak_val1: got %0d want 5", ch(peak_out, 0)); else n_pass++;
        wait_valid(20, lat);
        exp_seq++;
        n_checks++; if (ch(count_out, 0) !== 11'd9) $display("FAIL peak_cnt2: got %0d want 9", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(peak_out, 0) !== 11'd9) $display("FAIL peak_val2: got %0d want 9", ch(peak_out, 0)); else n_pass++;
        wait_valid(20, lat);
        exp_seq++;
        n_checks++; if (ch(count_out, 0) !== 11'd3) $display("FAIL peak_cnt3: got %0d want 3", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(peak_out, 0) !== 11'd9) $display("FAIL peak_val3: got %0d want 9", ch(peak_out, 0)); else n_pass++;
        repeat (15) step();
        peak_clr = 1'b1;
        wait_valid(5, lat);
        peak_clr = 1'b0;
        exp_seq++;
        n_checks++; if (lat !== 1) $display("FAIL peak_clr_pub_lat: got %0d want 1", lat); else n_pass++;
        n_checks++; if (ch(peak_out, 0) !== 11'd3) $display("FAIL peak_clr_pub0: got %0d want 3", ch(peak_out, 0)); else n_pass++;
        n_checks++; if (ch(peak_out, 1) !== 11'd16) $display("FAIL peak_clr_pub1: got %0d want 16", ch(peak_out, 1)); else n_pass++;
        n_checks++; if (window_seq !== 8'(exp_seq)) $display("FAIL peak_seq: got %0d want %0d", window_seq, exp_seq); else n_pass++;
        stop();
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        n_checks++; if (peak_out !== '0) $display("FAIL peak_clr_alone: got %h want 0", peak_out); else n_pass++;
    endtask

    task automatic test_enable_abort();
        int lat;
        int nv;
        win_log2 = 4'd3;
        start_run(0);
        repeat (5) step();
        enable = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (count_valid === 1'b1) nv++;
        end
        n_checks++; if (nv !== 0) $display("FAIL abort_no_pulse: got %0d pulses want 0", nv); else n_pass++;
        n_checks++; if (window_seq !== 8'(exp_seq)) $display("FAIL abort_seq_hold: got %0d want %0d", window_seq, exp_seq); else n_pass++;
        start_run(5);
        wait_valid(20, lat);
        exp_seq++;
        n_checks++; if (lat !== 8) $display("FAIL abort_lat: got %0d want 8", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd0) $display("FAIL abort_ch0: got %0d want 0", ch(count_out, 0)); else n_pass++;
        n_checks++; if (ch(count_out, 1) !== 11'd8) $display("FAIL abort_ch1: got %0d want 8", ch(count_out, 1)); else n_pass++;
        n_checks++; if (window_seq !== 8'(exp_seq)) $display("FAIL abort_seq: got %0d want %0d", window_seq, exp_seq); else n_pass++;
        stop();
    endtask

    task automatic test_reset_mid();
        int lat;
        win_log2 = 4'd3;
        start_run(0);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_seq = 0;
        n_checks++; if (count_out !== '0) $display("FAIL rmid_count: got %h want 0", count_out); else n_pass++;
        n_checks++; if (peak_out !== '0) $display("FAIL rmid_peak: got %h want 0", peak_out); else n_pass++;
        n_checks++; if (window_seq !== 8'd0) $display("FAIL rmid_seq: got %0d want 0", window_seq); else n_pass++;
        n_checks++; if (count_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", count_valid); else n_pass++;
        // Synchroniser was cleared too, so the first two samples of the new group read 0.
        wait_valid(20, lat);
        exp_seq++;
        n_checks++; if (lat !== 8) $display("FAIL rmid_lat: got %0d want 8", lat); else n_pass++;
        n_checks++; if (ch(count_out, 0) !== 11'd6) $display("FAIL rmid_ch0: got %0d want 6", ch(count_out, 0)); else n_pass++;
        n_checks++; if (window_seq !== 8'd1) $display("FAIL rmid_seq1: got %0d want 1", window_seq); else n_pass++;
        stop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_and_full();
        test_average();
        test_win_change();
        test_peak();
        test_enable_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
